result_display_driver: RTL

RESULT_DISPLAY_DRIVER -- requirements
Module: result_display_driver

---
 rtl/result_display_driver.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/result_display_driver.sv
// Converts an 8-bit result to three BCD digits (double dabble, one step per clock)
// and time-multiplexes them onto a common-anode 7-segment display with leading-zero blanking.
module result_display_driver #(
    parameter int REFRESH_DIV = 50000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] value_in,
    input  logic       load,
    output logic       busy,
    output logic       done,
    output logic [2:0] an,
    output logic [6:0] seg
);

    localparam int DIV_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(REFRESH_DIV - 1);
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        CONVERT = 1'b1
    } state_t;

    state_t     state, state_next;
    logic       capture, finish;
    logic [2:0] step;
    logic [7:0] bin_sr;
    logic [11:0] bcd, bcd_adj;
    logic [19:0] dabble_next;
    logic [11:0] disp;
    logic [DIV_W-1:0] div_cnt;
    logic [1:0] dig;
    logic [2:0] an_sel;
    logic [6:0] seg_sel;

    function automatic logic [3:0] dabble(input logic [3:0] n);
        return (n >= 4'd5) ? n + 4'd3 : n;
    endfunction

    function automatic logic [6:0] seg_decode(input logic [3:0] n);
        case (n)
            4'd0:    return 7'b1000000;
            4'd1:    return 7'b1111001;
            4'd2:    return 7'b0100100;
            4'd3:    return 7'b0110000;
            4'd4:    return 7'b0011001;
            4'd5:    return 7'b0010010;
            4'd6:    return 7'b0000010;
            4'd7:    return 7'b1111000;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0010000;
            default: return SEG_BLANK;
        endcase
    endfunction

    always_comb begin
        state_next = state;
        capture    = 1'b0;
        finish     = 1'b0;
        case (state)
            IDLE: begin
                if (load) begin
                    capture    = 1'b1;
                    state_next = CONVERT;
                end
            end
            CONVERT: begin
                if (step == 3'd7) begin
                    finish     = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    assign busy        = (state == CONVERT);
    assign bcd_adj     = {dabble(bcd[11:8]), dabble(bcd[7:4]), dabble(bcd[3:0])};
    assign dabble_next = {bcd_adj, bin_sr} << 1;

    // Conversion datapath: carries no reset, the FSM decides when it is meaningful.
    always_ff @(posedge clk) begin
        if (capture) begin
            bin_sr <= value_in;
            bcd    <= 12'd0;
        end else if (state == CONVERT) begin
            bcd    <= dabble_next[19:8];
            bin_sr <= dabble_next[7:0];
        end
    end

    // Display register only ever takes a completed conversion, so an aborted one leaves no trace.
    always_ff @(posedge clk) begin
        if (reset) begin
            step <= 3'd0;
            done <= 1'b0;
            disp <= 12'd0;
        end else begin
            done <= finish;
            if (capture)               step <= 3'd0;
            else if (state == CONVERT) step <= step + 3'd1;
            if (finish)                disp <= dabble_next[19:8];
        end
    end

    always_comb begin
        an_sel  = 3'b111;
        seg_sel = SEG_BLANK;
        case (dig)
            2'd0: begin
                an_sel  = 3'b110;
                seg_sel = seg_decode(disp[3:0]);
            end
            2'd1: begin
                an_sel  = 3'b101;
                seg_sel = (disp[11:8] == 4'd0 && disp[7:4] == 4'd0) ? SEG_BLANK
                                                                    : seg_decode(disp[7:4]);
            end
            2'd2: begin
                an_sel  = 3'b011;
                seg_sel = (disp[11:8] == 4'd0) ? SEG_BLANK : seg_decode(disp[11:8]);
            end
            default: begin
                an_sel  = 3'b111;
                seg_sel = SEG_BLANK;
            end
        endcase
    end

    // Scan runs freely, independent of the converter.
    always_ff @(posedge clk) begin
        if (reset) begin
            div_cnt <= '0;
            dig     <= 2'd0;
            an      <= 3'b110;
            seg     <= 7'b1000000;
        end else begin
            if (div_cnt == DIV_LAST) begin
                div_cnt <= '0;
                dig     <= (dig == 2'd2) ? 2'd0 : dig + 2'd1;
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end
            an  <= an_sel;
            seg <= seg_sel;
        end
    end

endmodule
